// File: rtl/decode_pkg.sv
// Shared opcode constants, format tag and decoded control bundle for the decode stage.
// The XLEN-wide immediate and PC travel beside dec_ctrl_t because a package struct cannot take XLEN.
package decode_pkg;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_SYS = 3'd6,
        FMT_BAD = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1_en;
        logic       rs2_en;
        logic       rd_we;
        fmt_e       fmt;
        logic       illegal;
    } dec_ctrl_t;

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32I/RV64I + Zicsr + Zifencei decoder: raw instruction -> control bundle and XLEN immediate.
// Register index fields are zero whenever the matching enable is off; unrecognised encodings give FMT_BAD.
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output dec_ctrl_t       ctrl_o,
    output logic [XLEN-1:0] imm_o
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ok;
    logic        has_rd;
    logic        rs1_en;
    logic        rs2_en;
    logic        sh_zero;
    logic        sh_alt;
    fmt_e        fmt;
    logic [31:0] imm32;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];

    // On RV64 instr[25] is shamt[5], so only the upper six bits qualify a shift.
    always_comb begin
        if (XLEN == 64) begin
            sh_zero = (instr_i[31:26] == 6'b000000);
            sh_alt  = (instr_i[31:26] == 6'b010000);
        end else begin
            sh_zero = (f7 == 7'b0000000);
            sh_alt  = (f7 == 7'b0100000);
        end
    end

    always_comb begin
        ok     = 1'b0;
        has_rd = 1'b0;
        rs1_en = 1'b0;
        rs2_en = 1'b0;
        fmt    = FMT_BAD;
        imm32  = '0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                ok = 1'b1; fmt = FMT_U; has_rd = 1'b1;
                imm32 = {instr_i[31:12], 12'b0};
            end
            OP_JAL: begin
                ok = 1'b1; fmt = FMT_J; has_rd = 1'b1;
                imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                fmt = FMT_I; has_rd = 1'b1; rs1_en = 1'b1;
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
                if (opcode == OP_JALR)
                    ok = (f3 == 3'b000);
                else if (opcode == OP_LOAD)
                    ok = (f3 != 3'b111) && (f3 != 3'b110 || XLEN == 64) && (f3 != 3'b011 || XLEN == 64);
                else if (f3 == 3'b001)
                    ok = sh_zero;
                else if (f3 == 3'b101)
                    ok = sh_zero || sh_alt;
                else
                    ok = 1'b1;
            end
            OP_STORE: begin
                fmt = FMT_S; rs1_en = 1'b1; rs2_en = 1'b1;
                ok = (f3 <= 3'b010) || (f3 == 3'b011 && XLEN == 64);
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OP_BRANCH: begin
                fmt = FMT_B; rs1_en = 1'b1; rs2_en = 1'b1;
                ok = (f3 != 3'b010) && (f3 != 3'b011);
                imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OP_OP: begin
                fmt = FMT_R; has_rd = 1'b1; rs1_en = 1'b1; rs2_en = 1'b1;
                ok = (f7 == 7'b0000000) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
            end
            OP_MISC_MEM: begin
                fmt = FMT_SYS;
                ok = (f3 == 3'b000) || (f3 == 3'b001);
            end
            OP_SYSTEM: begin
                if (f3 == 3'b000) begin
                    fmt = FMT_SYS;
                    ok = (instr_i == 32'h0000_0073) || (instr_i == 32'h0010_0073);
                    imm32 = {31'b0, instr_i[20]};
                end else if (f3 != 3'b100) begin
                    ok = 1'b1; fmt = FMT_I; has_rd = 1'b1;
                    rs1_en = ~f3[2];
                    imm32 = f3[2] ? {27'b0, instr_i[19:15]} : {{20{instr_i[31]}}, instr_i[31:20]};
                end
            end
            default: ok = 1'b0;
        endcase
    end

    always_comb begin
        ctrl_o = '0;
        imm_o  = '0;
        if (ok) begin
            ctrl_o.fmt    = fmt;
            ctrl_o.rd     = has_rd ? instr_i[11:7] : 5'd0;
            ctrl_o.rd_we  = has_rd && (instr_i[11:7] != 5'd0);
            ctrl_o.rs1    = rs1_en ? instr_i[19:15] : 5'd0;
            ctrl_o.rs2    = rs2_en ? instr_i[24:20] : 5'd0;
            ctrl_o.rs1_en = rs1_en;
            ctrl_o.rs2_en = rs2_en;
            imm_o         = XLEN'($signed(imm32));
        end else begin
            ctrl_o.fmt     = FMT_BAD;
            ctrl_o.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready handshake, registered flush and saturating illegal counter.
// Define DECODE_SKID_EN for a 1-entry skid buffer that makes in_ready a register output.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic             out_rs1_en,
    output logic             out_rs2_en,
    output logic             out_rd_we,
    output logic [2:0]       out_fmt,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    // Handshake: a side transfers on a cycle where its valid and ready are both high at the rising edge.
    dec_ctrl_t        dec_ctrl;
    logic [XLEN-1:0]  dec_imm;
    logic             out_valid_q, out_valid_d;
    dec_ctrl_t        ctrl_q, ctrl_d;
    logic [XLEN-1:0]  imm_q, imm_d, pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_xfer, out_xfer, out_free;

    decode_comb #(.XLEN(XLEN)) u_decode_comb (
        .instr_i (in_instr),
        .ctrl_o  (dec_ctrl),
        .imm_o   (dec_imm)
    );

    assign out_xfer = out_valid_q && out_ready;
    assign out_free = !out_valid_q || out_ready;
    assign in_xfer  = in_valid && in_ready;

`ifdef DECODE_SKID_EN
    logic             skid_valid_q, skid_valid_d;
    dec_ctrl_t        skid_ctrl_q, skid_ctrl_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d, skid_pc_q, skid_pc_d;

    assign in_ready = !skid_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_imm_q   <= '0;
            skid_pc_q    <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_imm_q   <= skid_imm_d;
            skid_pc_q    <= skid_pc_d;
        end
    end
`else
    assign in_ready = out_free;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        imm_d       = imm_q;
        pc_d        = pc_q;
`ifdef DECODE_SKID_EN
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_imm_d   = skid_imm_q;
        skid_pc_d    = skid_pc_q;
        if (flush) begin
            out_valid_d = 1'b0; ctrl_d = '0; imm_d = '0; pc_d = '0;
            skid_valid_d = 1'b0; skid_ctrl_d = '0; skid_imm_d = '0; skid_pc_d = '0;
        end else if (out_free && skid_valid_q) begin
            out_valid_d  = 1'b1;
            ctrl_d       = skid_ctrl_q;
            imm_d        = skid_imm_q;
            pc_d         = skid_pc_q;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            out_valid_d = in_xfer;
            if (in_xfer) begin
                ctrl_d = dec_ctrl; imm_d = dec_imm; pc_d = in_pc;
            end
        end else if (in_xfer) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = dec_ctrl;
            skid_imm_d   = dec_imm;
            skid_pc_d    = in_pc;
        end
`else
        if (flush) begin
            out_valid_d = 1'b0; ctrl_d = '0; imm_d = '0; pc_d = '0;
        end else if (out_free) begin
            out_valid_d = in_xfer;
            if (in_xfer) begin
                ctrl_d = dec_ctrl; imm_d = dec_imm; pc_d = in_pc;
            end
        end
`endif
    end

    // A flush discards the held bundle, so it is not counted even if out_ready is high.
    always_comb begin
        cnt_d = cnt_q;
        if (out_xfer && ctrl_q.illegal && !flush && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            imm_q       <= imm_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = pc_q;
    assign out_rd      = ctrl_q.rd;
    assign out_rs1     = ctrl_q.rs1;
    assign out_rs2     = ctrl_q.rs2;
    assign out_rs1_en  = ctrl_q.rs1_en;
    assign out_rs2_en  = ctrl_q.rs2_en;
    assign out_rd_we   = ctrl_q.rd_we;
    assign out_fmt     = ctrl_q.fmt;
    assign out_imm     = imm_q;
    assign out_illegal = ctrl_q.illegal;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: field decode, stall/stream ordering, illegal counting, flush and reset.
// A second instance with CNT_W=2 shares every input to exercise counter saturation.
module tb_decode_stage;
    import decode_pkg::*;

    localparam int XLEN = 32;
`ifdef DECODE_SKID_EN
    localparam logic SKID_EXP1 = 1'b1;
`else
    localparam logic SKID_EXP1 = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rd, out_rs1, out_rs2;
    logic            out_rs1_en, out_rs2_en, out_rd_we;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;
    logic [15:0]     illegal_cnt;

    logic            in_ready_b, out_valid_b;
    logic [XLEN-1:0] out_pc_b, out_imm_b;
    logic [4:0]      out_rd_b, out_rs1_b, out_rs2_b;
    logic            out_rs1_en_b, out_rs2_en_b, out_rd_we_b, out_illegal_b;
    logic [2:0]      out_fmt_b;
    logic [1:0]      illegal_cnt_b;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en), .out_rd_we(out_rd_we),
        .out_fmt(out_fmt), .out_imm(out_imm), .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt)
    );

    decode_stage #(.XLEN(XLEN), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(out_pc_b),
        .out_rd(out_rd_b), .out_rs1(out_rs1_b), .out_rs2(out_rs2_b),
        .out_rs1_en(out_rs1_en_b), .out_rs2_en(out_rs2_en_b), .out_rd_we(out_rd_we_b),
        .out_fmt(out_fmt_b), .out_imm(out_imm_b), .out_illegal(out_illegal_b),
        .illegal_cnt(illegal_cnt_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]     s_instr[3];
        logic [XLEN-1:0] s_pc[3];
        logic [36:0]     snap, exp;
        logic            acc, took, stalled, done;
        int              idx;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_imm", out_imm, 0);
        check("rst_cnt", illegal_cnt, 0);
        rst = 1'b0;
        #1;
        check("rst_ready", in_ready, 1);
        check("rst_fields", {out_rd, out_rs1, out_rs2, out_rd_we, out_illegal, out_pc}, 0);

        // legal decode, out_ready held high
        out_ready = 1'b1;
        send(32'hFFF0_0093, 32'h100);
        check("addi_valid", out_valid, 1);
        check("addi_rd", out_rd, 1);
        check("addi_rs1", out_rs1, 0);
        check("addi_en", {out_rs1_en, out_rs2_en, out_rd_we}, 3'b101);
        check("addi_fmt", out_fmt, FMT_I);
        check("addi_imm", out_imm, 32'hFFFF_FFFF);
        check("addi_pc", out_pc, 32'h100);
        check("addi_ill", out_illegal, 0);

        send(32'h1234_52B7, 32'h104);
        check("lui_rd", out_rd, 5);
        check("lui_fmt", out_fmt, FMT_U);
        check("lui_imm", out_imm, 32'h1234_5000);
        check("lui_en", {out_rs1_en, out_rs2_en, out_rd_we}, 3'b001);

        send(32'h0010_00EF, 32'h108);
        check("jal_fmt", out_fmt, FMT_J);
        check("jal_imm", out_imm, 32'h0000_0800);
        check("jal_rd", out_rd, 1);

        send(32'hFE20_8EE3, 32'h10C);
        check("beq_regs", {out_rd, out_rs1, out_rs2}, {5'd0, 5'd1, 5'd2});
        check("beq_en", {out_rs1_en, out_rs2_en, out_rd_we}, 3'b110);
        check("beq_fmt", out_fmt, FMT_B);
        check("beq_imm", out_imm, 32'hFFFF_FFFC);

        send(32'h0020_A423, 32'h110);
        check("sw_fmt", out_fmt, FMT_S);
        check("sw_imm", out_imm, 32'h8);
        check("sw_regs", {out_rd, out_rs1, out_rs2, out_rd_we}, {5'd0, 5'd1, 5'd2, 1'b0});

        send(32'h4031_00B3, 32'h114);
        check("sub_fmt", out_fmt, FMT_R);
        check("sub_regs", {out_rd, out_rs1, out_rs2}, {5'd1, 5'd2, 5'd3});
        check("sub_imm", out_imm, 0);
        check("sub_ill", out_illegal, 0);

        send(32'h4020_D093, 32'h118);
        check("srai_fmt", out_fmt, FMT_I);
        check("srai_imm", out_imm, 32'h402);

        send(32'h0000_0073, 32'h11C);
        check("ecall_fmt", out_fmt, FMT_SYS);
        check("ecall_imm", out_imm, 0);
        check("ecall_en", {out_rs1_en, out_rs2_en, out_rd_we, out_rd, out_rs1}, 0);

        send(32'h0010_0073, 32'h120);
        check("ebreak_imm", out_imm, 1);
        check("ebreak_fmt", out_fmt, FMT_SYS);
        tick();
        check("drain_valid", out_valid, 0);
        check("legal_cnt", illegal_cnt, 0);

        // illegal encodings
        send(32'h0000_0000, 32'h140);
        check("zero_ill", {out_illegal, out_fmt}, {1'b1, FMT_BAD});
        check("zero_en", {out_rs1_en, out_rs2_en, out_rd_we}, 0);
        send(32'h0231_00B3, 32'h144);
        check("addf7_ill", {out_illegal, out_fmt}, {1'b1, FMT_BAD});
        tick();
        check("ill_cnt2", illegal_cnt, 2);
        check("ill_cnt2_sat", illegal_cnt_b, 2);

        send(32'hFFFF_FFFF, 32'h148);
        check("ones_ill", out_illegal, 1);
        send(32'h4020_9093, 32'h14C);
        check("slli_alt_ill", {out_illegal, out_fmt}, {1'b1, FMT_BAD});
        send(32'h0000_0001, 32'h150);
        check("c_ext_ill", {out_illegal, out_fmt}, {1'b1, FMT_BAD});
        tick();
        check("ill_cnt5", illegal_cnt, 5);
        check("ill_cnt_sat", illegal_cnt_b, 3);

        // stream A,B,C with 3 stalled cycles
        s_instr[0] = 32'h0010_0093; s_pc[0] = 32'h200;
        s_instr[1] = 32'h0020_0113; s_pc[1] = 32'h204;
        s_instr[2] = 32'h0030_0193; s_pc[2] = 32'h208;
        exp_q.push_back({s_pc[0], 5'd1});
        exp_q.push_back({s_pc[1], 5'd2});
        exp_q.push_back({s_pc[2], 5'd3});
        idx  = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            out_ready = (cyc >= 3);
            in_valid  = (idx < 3);
            in_instr  = s_instr[(idx < 3) ? idx : 0];
            in_pc     = s_pc[(idx < 3) ? idx : 0];
            #1;
            if (cyc == 1) check("stall_ready_c1", in_ready, SKID_EXP1);
            if (cyc == 2) check("stall_ready_c2", in_ready, 0);
            acc     = in_valid && in_ready;
            took    = out_valid && out_ready;
            stalled = out_valid && !out_ready;
            snap    = {out_pc, out_rd};
            tick();
            if (acc) idx++;
            if (took) begin
                check("stream_extra", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp = exp_q.pop_front();
                    check("stream_order", snap, exp);
                end
            end
            if (stalled) check("stall_stable", {out_valid, out_pc, out_rd}, {1'b1, snap});
            done = (idx == 3) && (exp_q.size() == 0);
        end
        in_valid = 1'b0;
        check("stream_done", done, 1);
        tick();
        check("stream_idle", out_valid, 0);

        // flush with a stalled illegal bundle and a competing input
        out_ready = 1'b0;
        send(32'h0000_0000, 32'h300);
        check("flush_pre", {out_valid, out_illegal}, 2'b11);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'hFFFF_FFFF; in_pc = 32'h304;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_pc", out_pc, 0);
        check("flush_ready", in_ready, 1);
        out_ready = 1'b1;
        tick();
        tick();
        check("flush_none", out_valid, 0);
        check("flush_cnt", illegal_cnt, 5);

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        send(32'h0010_0093, 32'h400);
        check("mrst_pre", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mrst_valid", out_valid, 0);
        check("mrst_fields", {out_rd, out_rs1, out_rs1_en, out_rd_we, out_imm, out_pc}, 0);
        check("mrst_cnt", illegal_cnt, 0);
        check("mrst_ready", in_ready, 1);
        tick();
        rst = 1'b0;
        tick();
        check("mrst_quiet", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised RISC-V (RV32I/RV64I base + Zicsr + Zifencei) decode pipeline stage between fetch and register-read/execute.
- Decodes the raw 32-bit instruction directly from opcode/funct fields into register indices, enables, format tag and sign-extended XLEN immediate.
- Adds what the previous combinational decoder lacked:
  - valid/ready handshake with backpressure;
  - pipeline flush;
  - illegal-instruction detection with a saturating counter.

Parameters:
- XLEN, 32, datapath/immediate/PC width; legal values 32 or 64.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard held and in-flight instructions
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts an instruction this cycle
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  PC of in_instr
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts the bundle
- out_pc  out  XLEN  PC passed through
- out_rd  out  5  destination register index
- out_rs1, out_rs2  out  5 each  source register indices
- out_rs1_en, out_rs2_en  out  1 each  source is read
- out_rd_we  out  1  rd written: format has rd and rd != 0
- out_fmt  out  3  fmt_e: R, I, S, B, U, J, SYS, BAD
- out_imm  out  XLEN  sign-extended immediate
- out_illegal  out  1  encoding not recognised
- illegal_cnt  out  CNT_W  saturating count of illegal instructions delivered

Behaviour:
- Reset: out_valid=0; all out_* fields=0; illegal_cnt=0; skid buffer empty; in_ready=1 once rst deasserts.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Latency is exactly 1 cycle from input transfer to out_valid.
- Output register:
  - Loads on an input transfer when it is empty or transferring this cycle.
  - Otherwise it holds; every out_* field stays stable while out_valid && !out_ready.
- Field rules per format (unused fields are driven 0, never X):
  - U (LUI, AUIPC): rd; imm = {instr[31:12], 12'b0}, sign-extended to XLEN.
  - J (JAL): rd; imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - I (JALR, loads, OP-IMM, CSR*): rd, rs1; imm = sext(instr[31:20]).
    - CSR*I variants: rs1_en=0 and imm = zero-extended instr[19:15].
    - Shift-immediates: legal only with funct7 0000000, or 0100000 with funct3 101.
  - S: rs1, rs2; imm = sext({instr[31:25], instr[11:7]}).
  - B: rs1, rs2; imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - R (OP): rd, rs1, rs2; imm=0. Only funct7 0000000, or 0100000 for ADD/SUB and SRL/SRA, is legal.
  - SYS: FENCE, FENCE.I, ECALL (imm=0), EBREAK (imm=1); rd=rs1=0; no enables.
  - Any other opcode, funct pattern, or instr[1:0] != 2'b11: fmt=BAD, out_illegal=1, all enables 0.
- Flush:
  - Registered. Output register and skid buffer are cleared on the next edge.
  - Flush beats a simultaneous input transfer; the accepted instruction is dropped.
  - in_ready remains per normal rules.
- illegal_cnt increments on each output transfer with out_illegal=1 and saturates at all-ones. Flushed instructions are not counted.
- Reset asserted mid-operation clears everything immediately (asynchronous); nothing is emitted after deassertion until a new input transfer.

Optional Feature:
- Macro: DECODE_SKID_EN.
- Defined:
  - 1-entry skid buffer; in_ready is a register output (= skid empty).
  - An input transfer while the output is stalled goes into the skid buffer.
  - The skid drains into the output register on the next output transfer.
  - Full throughput with no combinational path out_ready -> in_ready.
- Undefined:
  - No skid buffer; in_ready = !out_valid || out_ready (combinational).
- Both builds: identical ordering, latency and field results.

Decomposition:
- Package decode_pkg holds:
  - opcode constants: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP, OP_MISC_MEM, OP_SYSTEM;
  - the fmt_e enum;
  - the decoded-bundle packed struct, parametrised via XLEN-sized fields in the module.
- One sub-module, decode_comb: pure combinational instr -> bundle. decode_stage wraps it with the handshake, skid, flush and counter logic.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, rs1_en=1, rs2_en=0, rd_we=1, fmt=I, imm=0xFFFFFFFF. XLEN=64: imm=0xFFFFFFFFFFFFFFFF.
- LUI x5,0x12345 (0x123452B7) -> imm=0x12345000, rd=5, fmt=U. JAL x1,+2048 (0x001000EF) -> imm=0x00000800, fmt=J.
- BEQ x1,x2,-4 (0xFE208EE3) -> rs1=1, rs2=2, both enables set, rd_we=0, imm=0xFFFFFFFC. SW x2,8(x1) (0x0020A423) -> imm=8, fmt=S.
- Stream A,B,C with out_ready=0 for 3 cycles, then 1:
  - no loss, no duplication, order A,B,C;
  - outputs stable while stalled;
  - with DECODE_SKID_EN, in_ready drops only after the skid fills.
- Instruction 0x00000000, then ADD with funct7=0000001 -> out_illegal=1 and fmt=BAD on both; illegal_cnt=2. With CNT_W=2 and 5 illegals, the count sticks at 3.
- flush asserted in the same cycle as an input transfer while a bundle is stalled -> out_valid=0 next cycle, nothing emitted, illegal_cnt unchanged. rst pulsed mid-stream -> all outputs 0 immediately.
